// File: rtl/encoder_4to2_pkg.sv
// ---------------------------------------------------------------------------
// encoder_4to2_pkg
//   Shared definitions for the 4-to-2 priority encoder:
//     - 2-bit index codes for each request line
//     - count_ones(): population count of a 4-bit request vector
//   No ports (package).
// ---------------------------------------------------------------------------
package encoder_4to2_pkg;

    localparam logic [1:0] IDX_D0 = 2'b00;
    localparam logic [1:0] IDX_D1 = 2'b01;
    localparam logic [1:0] IDX_D2 = 2'b10;
    localparam logic [1:0] IDX_D3 = 2'b11;

    // Number of active request lines (0..4).
    function automatic logic [2:0] count_ones(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage : encoder_4to2_pkg

// File: rtl/encoder_4to2_comb.sv
// ---------------------------------------------------------------------------
// encoder_4to2_comb
//   Purely combinational 4-to-2 priority encoder.
//   Parameters:
//     HIGH_PRIORITY  1: highest active index wins; 0: lowest active index wins
//   Ports:
//     d      in  [3:0]  request lines (d[0] = D0 ... d[3] = D3)
//     idx    out [1:0]  index of the winning request (00 when none active)
//     valid  out        at least one request active
//     multi  out        two or more requests active
// ---------------------------------------------------------------------------
module encoder_4to2_comb
    import encoder_4to2_pkg::*;
#(
    parameter int HIGH_PRIORITY = 1
) (
    input  logic [3:0] d,
    output logic [1:0] idx,
    output logic       valid,
    output logic       multi
);

    always_comb begin
        idx = IDX_D0;
        if (HIGH_PRIORITY != 0) begin
            if (d[3])      idx = IDX_D3;
            else if (d[2]) idx = IDX_D2;
            else if (d[1]) idx = IDX_D1;
            else           idx = IDX_D0;
        end else begin
            if (d[0])      idx = IDX_D0;
            else if (d[1]) idx = IDX_D1;
            else if (d[2]) idx = IDX_D2;
            else if (d[3]) idx = IDX_D3;
            else           idx = IDX_D0;
        end
    end

    assign valid = |d;
    assign multi = (count_ones(d) >= 3'd2);

endmodule : encoder_4to2_comb

// File: rtl/encoder_4to2_reg.sv
// ---------------------------------------------------------------------------
// encoder_4to2_reg
//   4-to-2 priority encoder with valid/multi flags and an optional output
//   register stage.
//   Parameters:
//     HIGH_PRIORITY  1: D3 > D2 > D1 > D0;  0: D0 > D1 > D2 > D3
//     REG_OUT        1: outputs registered, 1-cycle latency, async reset
//                    0: outputs combinational, clk/rst_n unused
//   Ports:
//     clk     in   rising-edge clock
//     rst_n   in   asynchronous active-low reset
//     D0..D3  in   request lines (indices 00..11)
//     Y0, Y1  out  encoded index LSB / MSB
//     valid   out  at least one request active
//     multi   out  two or more requests active
// ---------------------------------------------------------------------------
module encoder_4to2_reg
    import encoder_4to2_pkg::*;
#(
    parameter int HIGH_PRIORITY = 1,
    parameter int REG_OUT       = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    output logic Y0,
    output logic Y1,
    output logic valid,
    output logic multi
);

    logic [1:0] idx_d;
    logic       valid_d;
    logic       multi_d;

    encoder_4to2_comb #(
        .HIGH_PRIORITY(HIGH_PRIORITY)
    ) u_comb (
        .d     ({D3, D2, D1, D0}),
        .idx   (idx_d),
        .valid (valid_d),
        .multi (multi_d)
    );

    generate
        if (REG_OUT != 0) begin : g_reg
            // All four outputs live in one register so they change together
            // on the same edge; no intermediate code is ever visible.
            logic [1:0] idx_q;
            logic       valid_q;
            logic       multi_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    idx_q   <= IDX_D0;
                    valid_q <= 1'b0;
                    multi_q <= 1'b0;
                end else begin
                    idx_q   <= idx_d;
                    valid_q <= valid_d;
                    multi_q <= multi_d;
                end
            end

            assign Y1    = idx_q[1];
            assign Y0    = idx_q[0];
            assign valid = valid_q;
            assign multi = multi_q;
        end else begin : g_bypass
            assign Y1    = idx_d[1];
            assign Y0    = idx_d[0];
            assign valid = valid_d;
            assign multi = multi_d;
        end
    endgenerate

endmodule : encoder_4to2_reg

// File: tb/tb_encoder_4to2_reg.sv
// ---------------------------------------------------------------------------
// tb_encoder_4to2_reg
//   Drives three encoder instances from the same request lines:
//     dut     : HIGH_PRIORITY=1, REG_OUT=1
//     dut_lp  : HIGH_PRIORITY=0, REG_OUT=1
//     dut_cmb : HIGH_PRIORITY=1, REG_OUT=0
//   Expected registered results are queued when a request pattern is
//   driven and popped one edge later. Result vector layout: {Y1,Y0,valid,multi}.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_encoder_4to2_reg;

    logic clk;
    logic rst_n;
    logic [3:0] d;

    logic y0_hp, y1_hp, valid_hp, multi_hp;
    logic y0_lp, y1_lp, valid_lp, multi_lp;
    logic y0_cb, y1_cb, valid_cb, multi_cb;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] hp;
        logic [3:0] lp;
        logic [3:0] din;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] last_hp;
    logic [3:0] last_lp;

    encoder_4to2_reg #(.HIGH_PRIORITY(1), .REG_OUT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .Y0(y0_hp), .Y1(y1_hp), .valid(valid_hp), .multi(multi_hp)
    );

    encoder_4to2_reg #(.HIGH_PRIORITY(0), .REG_OUT(1)) dut_lp (
        .clk(clk), .rst_n(rst_n),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .Y0(y0_lp), .Y1(y1_lp), .valid(valid_lp), .multi(multi_lp)
    );

    encoder_4to2_reg #(.HIGH_PRIORITY(1), .REG_OUT(0)) dut_cmb (
        .clk(clk), .rst_n(rst_n),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .Y0(y0_cb), .Y1(y1_cb), .valid(valid_cb), .multi(multi_cb)
    );

    wire [3:0] obs_hp = {y1_hp, y0_hp, valid_hp, multi_hp};
    wire [3:0] obs_lp = {y1_lp, y0_lp, valid_lp, multi_lp};
    wire [3:0] obs_cb = {y1_cb, y0_cb, valid_cb, multi_cb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: scan every line, remember first (low priority) or
    // last (high priority) active index, and count active lines.
    function automatic logic [3:0] model(input logic [3:0] v, input bit hp);
        logic [1:0] idx;
        bit         found;
        int         n;
        idx   = 2'b00;
        found = 1'b0;
        n     = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                n++;
                if (hp || !found) idx = 2'(i);
                found = 1'b1;
            end
        end
        return {idx, (n > 0), (n > 1)};
    endfunction

    task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got {Y1,Y0,valid,multi}=%b expected %b (d=%b)", tag, obs, exp, d);
        end
    endtask

    // Called at a falling edge. Drives the pattern, checks the combinational
    // instance and that registered outputs still hold the previous result,
    // then checks the registered result after the next rising edge.
    task automatic apply(input logic [3:0] v);
        exp_t e;
        d = v;
        e.hp  = model(v, 1'b1);
        e.lp  = model(v, 1'b0);
        e.din = v;
        sb_q.push_back(e);
        #1;
        check_val("comb_same_cycle", obs_cb, model(v, 1'b1));
        check_val("hp_hold_prev", obs_hp, last_hp);
        check_val("lp_hold_prev", obs_lp, last_lp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got size=0 expected size>0");
        end else begin
            e = sb_q.pop_front();
            check_val("hp_reg", obs_hp, e.hp);
            check_val("lp_reg", obs_lp, e.lp);
            $display("txn d=%b hp=%b lp=%b", e.din, obs_hp, obs_lp);
            last_hp = e.hp;
            last_lp = e.lp;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        last_hp  = 4'b0000;
        last_lp  = 4'b0000;

        // Reset held with D0 active: registered outputs stay cleared.
        rst_n = 1'b0;
        d     = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_hold_hp", obs_hp, 4'b0000);
        check_val("reset_hold_lp", obs_lp, 4'b0000);
        check_val("reset_comb_unaffected", obs_cb, 4'b0010);

        // Release; first edge loads the current input (D0 -> 00, valid=1).
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b0001);

        // One-hot sweep.
        apply(4'b0010);
        apply(4'b0100);
        apply(4'b1000);

        // No request.
        apply(4'b0000);

        // Multi-hot: high priority -> 11, low priority -> 01.
        apply(4'b1010);
        check_val("multihot_hp_explicit", obs_hp, 4'b1111);
        check_val("multihot_lp_explicit", obs_lp, 4'b0111);

        // Async reset mid-cycle after D3 has registered.
        apply(4'b1000);
        check_val("pre_async_reset", obs_hp, 4'b1110);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset_hp", obs_hp, 4'b0000);
        check_val("async_reset_lp", obs_lp, 4'b0000);
        @(negedge clk);
        rst_n   = 1'b1;
        last_hp = 4'b0000;
        last_lp = 4'b0000;

        // Exhaustive sweep of all 16 patterns, then random patterns.
        for (int i = 0; i < 16; i++) begin
            apply(4'(i));
        end
        for (int i = 0; i < 20; i++) begin
            apply(4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_encoder_4to2_reg
